// File: rtl/dpram_portb_arb_if.sv
// dpram_portb_arb_if: one requester's view of the shared RAM port B.
// Ports: req/we/wem/addr/wdata toward the arbiter, gnt/rvalid/rdata back.
interface dpram_portb_arb_if #(
   parameter int ADDR_W = 11
);
   logic              req;
   logic              we;
   logic [3:0]        wem;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              gnt;
   logic              rvalid;
   logic [31:0]       rdata;

   modport master (
      output req, we, wem, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, wem, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dpram_portb_arb.sv
// dpram_portb_arb: shares dual-port RAM port B between m0 (LSU) and m1 (bus).
// Ports: clk, rst (async, active-high), m0/m1 requester interfaces (slave
// modport), ram_addrb/dinb/web/wemb/enb to the RAM, ram_doutb from it.
// Macro DPRAM_ARB_RR_EN selects round-robin; otherwise fixed priority to m0
// with a starvation override for m1 after STARVE_LIM waiting cycles.
module dpram_portb_arb #(
   parameter int ADDR_W     = 11,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              rst,
   dpram_portb_arb_if.slave  m0,
   dpram_portb_arb_if.slave  m1,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [31:0]       ram_dinb,
   output logic              ram_web,
   output logic [3:0]        ram_wemb,
   output logic              ram_enb,
   input  logic [31:0]       ram_doutb
);

   logic win1;
   logic gnt0;
   logic gnt1;
   logic any_gnt;
   logic win_we;
   logic resp_vld;
   logic resp_id;
   logic resp_rd;

`ifdef DPRAM_ARB_RR_EN
   logic last_win;

   // On contention the port goes to whoever did not win last time.
   assign win1 = m1.req && (!m0.req || !last_win);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_win <= 1'b1;
      end else if (any_gnt) begin
         last_win <= gnt1;
      end
   end
`else
   logic [7:0] starve_cnt;

   assign win1 = m1.req && (!m0.req || starve_cnt == 8'(STARVE_LIM));

   // Counts consecutive cycles m1 has been kept waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 8'd0;
      end else if (m1.req && !gnt1) begin
         starve_cnt <= starve_cnt + 8'd1;
      end else begin
         starve_cnt <= 8'd0;
      end
   end
`endif

   assign gnt1    = !rst && win1;
   assign gnt0    = !rst && m0.req && !win1;
   assign any_gnt = gnt0 || gnt1;
   assign win_we  = gnt1 ? m1.we : m0.we;

   assign m0.gnt = gnt0;
   assign m1.gnt = gnt1;

   always_comb begin
      ram_enb   = 1'b0;
      ram_web   = 1'b0;
      ram_wemb  = 4'b0000;
      ram_addrb = '0;
      ram_dinb  = 32'h0;
      if (gnt1) begin
         ram_enb   = 1'b1;
         ram_web   = m1.we;
         ram_wemb  = m1.we ? m1.wem : 4'b0000;
         ram_addrb = m1.addr;
         ram_dinb  = m1.wdata;
      end else if (gnt0) begin
         ram_enb   = 1'b1;
         ram_web   = m0.we;
         ram_wemb  = m0.we ? m0.wem : 4'b0000;
         ram_addrb = m0.addr;
         ram_dinb  = m0.wdata;
      end
   end

   // Response stage lines up with the RAM's registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld <= 1'b0;
         resp_id  <= 1'b0;
         resp_rd  <= 1'b0;
      end else begin
         resp_vld <= any_gnt;
         resp_id  <= gnt1;
         resp_rd  <= any_gnt && !win_we;
      end
   end

   assign m0.rvalid = resp_vld && !resp_id;
   assign m1.rvalid = resp_vld && resp_id;
   assign m0.rdata  = (m0.rvalid && resp_rd) ? ram_doutb : 32'h0;
   assign m1.rdata  = (m1.rvalid && resp_rd) ? ram_doutb : 32'h0;

endmodule

// File: tb/tb_dpram_portb_arb.sv
// tb_dpram_portb_arb: bench for dpram_portb_arb with a RAM model and a
// transaction-level reference checked every cycle.
module tb_dpram_portb_arb;
   localparam int AW  = 11;
   localparam int LIM = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dpram_portb_arb_if #(.ADDR_W(AW)) m0_if ();
   dpram_portb_arb_if #(.ADDR_W(AW)) m1_if ();

   logic [AW-1:0] ram_addrb;
   logic [31:0]   ram_dinb;
   logic          ram_web;
   logic [3:0]    ram_wemb;
   logic          ram_enb;
   logic [31:0]   ram_doutb;

   dpram_portb_arb #(.ADDR_W(AW), .STARVE_LIM(LIM)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .ram_addrb (ram_addrb),
      .ram_dinb  (ram_dinb),
      .ram_web   (ram_web),
      .ram_wemb  (ram_wemb),
      .ram_enb   (ram_enb),
      .ram_doutb (ram_doutb)
   );

   // RAM port-B model with registered output
   logic [31:0] mem [0:2**AW-1];
   always @(posedge clk) begin
      if (ram_enb) begin
         ram_doutb <= mem[ram_addrb];
         if (ram_web)
            for (int b = 0; b < 4; b++)
               if (ram_wemb[b]) mem[ram_addrb][8*b+:8] <= ram_dinb[8*b+:8];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model state
   logic [31:0] ref_mem [0:2**AW-1];
   logic        pend_vld;
   logic        pend_id;
   logic        pend_rd;
   logic [31:0] pend_data;
   int          wait_cnt;
   logic        last_w;
   logic        acc0;
   logic        acc1;

   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         mem[i]     = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
         ref_mem[i] = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
      end
      mem[11'h010]     = 32'hDEADBEEF;
      ref_mem[11'h010] = 32'hDEADBEEF;
      mem[11'h020]     = 32'hAAAAAAAA;
      ref_mem[11'h020] = 32'hAAAAAAAA;
   end

   // compare process: one model step per cycle
   always @(negedge clk) begin
      logic r0, r1, w0, w1, e_en, e_we;
      logic [3:0]    e_wem;
      logic [AW-1:0] e_addr;
      logic [31:0]   e_din;
      #1;
      if (rst) begin
         chk("rst_gnt0", 32'(m0_if.gnt), 32'd0);
         chk("rst_gnt1", 32'(m1_if.gnt), 32'd0);
         chk("rst_enb", 32'(ram_enb), 32'd0);
         chk("rst_rvalid0", 32'(m0_if.rvalid), 32'd0);
         chk("rst_rvalid1", 32'(m1_if.rvalid), 32'd0);
         chk("rst_rdata0", m0_if.rdata, 32'd0);
         chk("rst_rdata1", m1_if.rdata, 32'd0);
         pend_vld = 1'b0;
         pend_id  = 1'b0;
         pend_rd  = 1'b0;
         wait_cnt = 0;
         last_w   = 1'b1;
         acc0     = 1'b0;
         acc1     = 1'b0;
      end else begin
         r0 = m0_if.req;
         r1 = m1_if.req;
`ifdef DPRAM_ARB_RR_EN
         w1 = r1 && (!r0 || last_w == 1'b0);
`else
         w1 = r1 && (!r0 || wait_cnt == LIM);
`endif
         w0 = r0 && !w1;
         e_en   = w0 || w1;
         e_we   = 1'b0;
         e_wem  = 4'b0;
         e_addr = '0;
         e_din  = 32'h0;
         if (w1) begin
            e_we = m1_if.we; e_addr = m1_if.addr; e_din = m1_if.wdata;
            e_wem = m1_if.we ? m1_if.wem : 4'b0;
         end else if (w0) begin
            e_we = m0_if.we; e_addr = m0_if.addr; e_din = m0_if.wdata;
            e_wem = m0_if.we ? m0_if.wem : 4'b0;
         end
         chk("gnt0", 32'(m0_if.gnt), 32'(w0));
         chk("gnt1", 32'(m1_if.gnt), 32'(w1));
         chk("enb", 32'(ram_enb), 32'(e_en));
         chk("web", 32'(ram_web), 32'(e_we));
         chk("wemb", 32'(ram_wemb), 32'(e_wem));
         chk("addrb", 32'(ram_addrb), 32'(e_addr));
         chk("dinb", ram_dinb, e_din);
         chk("rvalid0", 32'(m0_if.rvalid), 32'(pend_vld && !pend_id));
         chk("rvalid1", 32'(m1_if.rvalid), 32'(pend_vld && pend_id));
         chk("rdata0", m0_if.rdata,
             (pend_vld && !pend_id && pend_rd) ? pend_data : 32'h0);
         chk("rdata1", m1_if.rdata,
             (pend_vld && pend_id && pend_rd) ? pend_data : 32'h0);
         pend_vld = e_en;
         pend_id  = w1;
         pend_rd  = e_en && !e_we;
         if (e_en) begin
            if (e_we) begin
               for (int b = 0; b < 4; b++)
                  if (e_wem[b]) ref_mem[e_addr][8*b+:8] = e_din[8*b+:8];
            end else begin
               pend_data = ref_mem[e_addr];
            end
            last_w = w1;
         end
         wait_cnt = (r1 && !w1) ? wait_cnt + 1 : 0;
         acc0 = m0_if.gnt;
         acc1 = m1_if.gnt;
      end
   end

   task automatic set_req(input bit id, input logic rq, input logic we,
                          input logic [3:0] wem, input logic [AW-1:0] a,
                          input logic [31:0] d);
      if (id) begin
         m1_if.req = rq; m1_if.we = we; m1_if.wem = wem;
         m1_if.addr = a; m1_if.wdata = d;
      end else begin
         m0_if.req = rq; m0_if.we = we; m0_if.wem = wem;
         m0_if.addr = a; m0_if.wdata = d;
      end
   endtask

   task automatic rnd_req(input bit id);
      set_req(id, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom),
              AW'(11'h100 + 11'($urandom_range(0, 15))), $urandom);
   endtask

   task automatic xfer(input bit id, input logic we, input logic [3:0] wem,
                       input logic [AW-1:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic rv,
                       output logic [AW-1:0] ga, output int wt);
      @(negedge clk);
      set_req(id, 1'b1, we, wem, a, d);
      #2;
      wt = 0;
      while (!(id ? m1_if.gnt : m0_if.gnt) && wt < 50) begin
         @(negedge clk);
         #2;
         wt++;
      end
      if (wt >= 50) begin
         checks++;
         errors++;
         $display("FAIL xfer_timeout: got no grant expected grant");
      end
      ga = ram_addrb;
      @(negedge clk);
      set_req(id, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      #2;
      rv = id ? m1_if.rvalid : m0_if.rvalid;
      rd = id ? m1_if.rdata : m0_if.rdata;
   endtask

   initial begin
      logic [31:0]   rd;
      logic          rv;
      logic [AW-1:0] ga;
      int            wt;
      int            mism;
      int            cnt1;
      bit            exp1;
      set_req(1'b0, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // m0 read of preloaded word
      xfer(1'b0, 1'b0, 4'b0, 11'h010, 32'h0, rd, rv, ga, wt);
      chk("t1_wait", 32'(wt), 32'd0);
      chk("t1_addr", 32'(ga), 32'h010);
      chk("t1_rvalid", 32'(rv), 32'd1);
      chk("t1_rdata", rd, 32'hDEADBEEF);

      // m1 partial write then read-back
      xfer(1'b1, 1'b1, 4'b0011, 11'h020, 32'h12345678, rd, rv, ga, wt);
      chk("t2_wr_rvalid", 32'(rv), 32'd1);
      chk("t2_wr_rdata", rd, 32'h0);
      xfer(1'b1, 1'b0, 4'b0, 11'h020, 32'h0, rd, rv, ga, wt);
      chk("t2_rd_rvalid", 32'(rv), 32'd1);
      chk("t2_rd_rdata", rd, 32'hAAAA5678);

      // continuous contention from a fresh reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 4'b0, 11'h005, 32'h0);
      set_req(1'b1, 1'b1, 1'b0, 4'b0, 11'h006, 32'h0);
      mism = 0;
      cnt1 = 0;
      for (int i = 0; i < 36; i++) begin
         #2;
`ifdef DPRAM_ARB_RR_EN
         exp1 = (i % 2) == 1;
`else
         exp1 = (i % (LIM + 1)) == LIM;
`endif
         if (m1_if.gnt !== exp1) mism++;
         if (m1_if.gnt === 1'b1) cnt1++;
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      chk("contention_pattern", 32'(mism), 32'd0);
`ifdef DPRAM_ARB_RR_EN
      chk("contention_m1_count", 32'(cnt1), 32'd18);
`else
      chk("contention_m1_count", 32'(cnt1), 32'd4);
`endif

      // random traffic, requests held until granted
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!m0_if.req || acc0) begin
            if ($urandom_range(0, 9) < 7) rnd_req(1'b0);
            else m0_if.req = 1'b0;
         end
         if (!m1_if.req || acc1) begin
            if ($urandom_range(0, 9) < 7) rnd_req(1'b1);
            else m1_if.req = 1'b0;
         end
      end
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 4'b0, '0, 32'h0);

      // reset asserted while a read response is pending
      @(negedge clk);
      set_req(1'b0, 1'b1, 1'b0, 4'b0, 11'h010, 32'h0);
      #2;
      chk("rstmid_gnt", 32'(m0_if.gnt), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("rstmid_rvalid0", 32'(m0_if.rvalid), 32'd0);
      chk("rstmid_gnt0", 32'(m0_if.gnt), 32'd0);
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0, 4'b0, '0, 32'h0);
      rst = 1'b0;

      // idle period then confirm memory untouched
      repeat (10) @(negedge clk);
      xfer(1'b0, 1'b0, 4'b0, 11'h010, 32'h0, rd, rv, ga, wt);
      chk("idle_rdata", rd, 32'hDEADBEEF);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
